// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: counter-width calculation and parameter legality check.
package fifo_pkg;

  // Bits needed to hold an occupancy value from 0 to depth inclusive.
  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Legal FIFO geometry: at least two entries and AE_LEVEL < AF_LEVEL <= DEPTH.
  function automatic bit params_ok(input int width, input int depth,
                                   input int ae_level, input int af_level);
    return (width >= 1) && (depth >= 2) && (ae_level >= 0) &&
           (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/sync_fifo_hs_if.sv
// Handshake bundle between a producer/consumer (master) and the FIFO (slave).
//
// Handshake semantics: a write transfers on a clock edge where wr_en && wr_ready;
// a read pops the head on an edge where rd_en && rd_valid. rd_data is the head
// word and is meaningful only while rd_valid. wr_ready/rd_valid come from
// registered state only, so a master may drive wr_en/rd_en from them freely.
// Requests made while not ready/valid are dropped and flagged as errors.
interface sync_fifo_hs_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  import fifo_pkg::*;

  localparam int CW = CNT_W(DEPTH);

  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic             almost_empty;
  logic             err_clr;
  logic             overflow;
  logic             underflow;

  modport master (
    output wr_en, wr_data, rd_en, err_clr,
    input  wr_ready, rd_data, rd_valid, count, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, err_clr,
    output wr_ready, rd_data, rd_valid, count, almost_full, almost_empty,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_rf.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port. Contents are intentionally not reset.
module fifo_mem_rf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Store the incoming word at the write address on an accepted write.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_hs.sv
// Single-clock first-word-fall-through FIFO with valid/ready handshake,
// occupancy count, almost-full/empty flags and sticky overflow/underflow.
module sync_fifo_hs
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 3,
  parameter int AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          rst,
  sync_fifo_hs_if.slave bus
);

  localparam int CW = CNT_W(DEPTH);
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  generate
    if (!params_ok(WIDTH, DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_params
      $error("sync_fifo_hs: illegal WIDTH/DEPTH/AE_LEVEL/AF_LEVEL combination");
    end
  endgenerate

  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_ready;
  logic             w_rd_valid;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [PW-1:0]    w_wr_ptr_nxt;
  logic [PW-1:0]    w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_rd_data;

  // Status decoded purely from the registered count, never from wr_en/rd_en.
  assign w_wr_ready = (r_count != FULL_CNT);
  assign w_rd_valid = (r_count != '0);
  assign w_wr_acc   = bus.wr_en & w_wr_ready;
  assign w_rd_acc   = bus.rd_en & w_rd_valid;

  // Explicit wrap so DEPTH need not be a power of two.
  assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);

  // Storage; writes are blocked while reset is held so nothing lands mid-reset.
  fifo_mem_rf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_wr_acc & ~rst),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  // Advance pointers on accepted transfers and track occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= w_wr_ptr_nxt;
      if (w_rd_acc) r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a new error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (bus.wr_en & ~w_wr_ready) | (r_overflow  & ~bus.err_clr);
      r_underflow <= (bus.rd_en & ~w_rd_valid) | (r_underflow & ~bus.err_clr);
    end
  end

  assign bus.wr_ready     = w_wr_ready;
  assign bus.rd_valid     = w_rd_valid;
  assign bus.rd_data      = w_rd_data;
  assign bus.count        = r_count;
  assign bus.almost_full  = (r_count >= AF_CNT);
  assign bus.almost_empty = (r_count <= AE_CNT);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_hs.sv
// Self-checking bench for sync_fifo_hs: table-driven vectors on a DEPTH=4
// instance, hand sequences for reset/latency/simultaneous access, random
// traffic, and a pointer-wrap run on a DEPTH=3 instance.
module tb_sync_fifo_hs;

  logic clk;
  logic rst;

  sync_fifo_hs_if #(.WIDTH(16), .DEPTH(4)) bus_a ();
  sync_fifo_hs_if #(.WIDTH(16), .DEPTH(3)) bus_b ();

  sync_fifo_hs #(.WIDTH(16), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sync_fifo_hs #(.WIDTH(16), .DEPTH(3), .AF_LEVEL(2), .AE_LEVEL(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  int          m_count = 0;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        clr;
    logic [15:0] data;
    int          cnt;
    logic        wrdy;
    logic        rv;
    logic        af;
    logic        ae;
    logic        ov;
    logic        un;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle on DUT A from the negedge; scoreboard pops on accepted reads
  // and pushes on accepted writes, using the bench's own occupancy model.
  task automatic step_a(input logic wr, input logic rd, input logic clr,
                        input logic [15:0] d);
    bit wa;
    bit ra;
    @(negedge clk);
    bus_a.wr_en   = wr;
    bus_a.rd_en   = rd;
    bus_a.err_clr = clr;
    bus_a.wr_data = d;
    wa = wr && (m_count != 4);
    ra = rd && (m_count != 0);
    if (ra) begin
      if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else                   chk("rd_data", {16'd0, bus_a.rd_data}, {16'd0, exp_q.pop_front()});
    end
    if (wa) exp_q.push_back(d);
    m_count = m_count + int'(wa) - int'(ra);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    @(negedge clk);
    bus_a.wr_en   = 1'b0;
    bus_a.rd_en   = 1'b0;
    bus_a.err_clr = 1'b0;
  endtask

  task automatic check_flags_a(input string tag, input vec_t v);
    chk({tag, "_count"}, 32'(bus_a.count), 32'(v.cnt));
    chk({tag, "_wr_ready"}, 32'(bus_a.wr_ready), 32'(v.wrdy));
    chk({tag, "_rd_valid"}, 32'(bus_a.rd_valid), 32'(v.rv));
    chk({tag, "_af"}, 32'(bus_a.almost_full), 32'(v.af));
    chk({tag, "_ae"}, 32'(bus_a.almost_empty), 32'(v.ae));
    chk({tag, "_ovf"}, 32'(bus_a.overflow), 32'(v.ov));
    chk({tag, "_unf"}, 32'(bus_a.underflow), 32'(v.un));
  endtask

  initial begin
    vec_t rst_v;
    logic [15:0] d;
    int q3_cnt;
    int pushed;
    int popped;
    logic [15:0] q3[$];

    //                 wr    rd    clr   data        cnt wrdy  rv    af    ae    ov    un
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'hA001, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'hA002, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'hA003, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'hA004, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'hA005, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'hA006, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'hA007, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 16'hA008, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rst_v    = '{1'b0, 1'b0, 1'b0, 16'h0000, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.err_clr = 1'b0; bus_a.wr_data = '0;
    bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.err_clr = 1'b0; bus_b.wr_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_flags_a("reset", rst_v);

    // Table-driven vectors: fill, overflow, full wr+rd, drain, underflow, err_clr.
    for (int i = 0; i < 16; i++) begin
      step_a(vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].data);
      check_flags_a($sformatf("vec%0d", i), vecs[i]);
    end
    idle_a();

    // Write-to-read latency: visible exactly one edge after the write, no read edge.
    @(negedge clk);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_data = 16'hD00F;
    #1;
    chk("lat_rv_before", 32'(bus_a.rd_valid), 32'd0);
    @(posedge clk);
    #1;
    bus_a.wr_en = 1'b0;
    chk("lat_rv_after", 32'(bus_a.rd_valid), 32'd1);
    chk("lat_rd_data", {16'd0, bus_a.rd_data}, 32'h0000D00F);
    exp_q.push_back(16'hD00F);
    m_count = 1;
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    chk("lat_drained", 32'(bus_a.rd_valid), 32'd0);

    // Simultaneous write+read at count=2 holds occupancy, order preserved.
    step_a(1'b1, 1'b0, 1'b0, 16'hB100);
    step_a(1'b1, 1'b0, 1'b0, 16'hB101);
    for (int i = 0; i < 5; i++) begin
      d = 16'(16'hB200 + i);
      step_a(1'b1, 1'b1, 1'b0, d);
      chk("simul_count", 32'(bus_a.count), 32'd2);
    end
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    chk("simul_empty", 32'(bus_a.count), 32'd0);

    // Reset mid-stream with count=3: clears immediately, stale data never returns.
    step_a(1'b1, 1'b0, 1'b0, 16'hC001);
    step_a(1'b1, 1'b0, 1'b0, 16'hC002);
    step_a(1'b1, 1'b0, 1'b0, 16'hC003);
    idle_a();
    chk("pre_rst_count", 32'(bus_a.count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", 32'(bus_a.count), 32'd0);
    chk("mid_rst_rd_valid", 32'(bus_a.rd_valid), 32'd0);
    chk("mid_rst_wr_ready", 32'(bus_a.wr_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    m_count = 0;
    step_a(1'b1, 1'b0, 1'b0, 16'hC0DE);
    chk("post_rst_count", 32'(bus_a.count), 32'd1);
    chk("post_rst_data", {16'd0, bus_a.rd_data}, 32'h0000C0DE);
    step_a(1'b0, 1'b1, 1'b0, 16'h0);
    chk("post_rst_empty", 32'(bus_a.rd_valid), 32'd0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 150; i++) begin
      step_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
             16'($urandom_range(0, 65535)));
      chk("rand_count", 32'(bus_a.count), 32'(m_count));
      chk("rand_wr_ready", 32'(bus_a.wr_ready), 32'(m_count != 4));
    end
    for (int i = 0; i < 8 && m_count != 0; i++) step_a(1'b0, 1'b1, 1'b0, 16'h0);
    chk("rand_drained", 32'(bus_a.count), 32'd0);
    idle_a();

    // Pointer wrap on DEPTH=3: 10 words interleaved, bounded cycle budget.
    q3_cnt = 0;
    pushed = 0;
    popped = 0;
    for (int cyc = 0; cyc < 300 && popped < 10; cyc++) begin
      bit wr;
      bit rd;
      bit wa;
      bit ra;
      @(negedge clk);
      wr = (pushed < 10) && ($urandom_range(0, 1) == 1);
      rd = ($urandom_range(0, 1) == 1);
      wa = wr && (q3_cnt != 3);
      ra = rd && (q3_cnt != 0);
      bus_b.wr_en   = wr;
      bus_b.rd_en   = rd;
      bus_b.wr_data = 16'(16'hE000 + pushed);
      if (ra) begin
        chk("wrap_data", {16'd0, bus_b.rd_data}, {16'd0, q3.pop_front()});
        popped++;
      end
      if (wa) begin
        q3.push_back(16'(16'hE000 + pushed));
        pushed++;
      end
      q3_cnt = q3_cnt + int'(wa) - int'(ra);
      @(posedge clk);
      #1;
      chk("wrap_count", 32'(bus_b.count), 32'(q3_cnt));
      chk("wrap_count_max", 32'(bus_b.count <= 2'd3), 32'd1);
    end
    chk("wrap_done", 32'(popped), 32'd10);
    @(negedge clk);
    bus_b.wr_en = 1'b0;
    bus_b.rd_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
